// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES decryption rounds.
// Holds the FSM encoding, the inverse S-box and the InvMixColumns multipliers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ROUNDS = 2'b01,
    FINAL  = 2'b11
  } inv_state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;

  // Entry i sits at bits [2047-8i -: 8], one S-box row per line.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = gf_xtime(gf_xtime(gf_xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = gf_xtime(b);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = gf_xtime(gf_xtime(b));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_inv_rounds_if.sv
// Block-level bus of aes_inv_rounds; abort exists only with AES_INV_ROUNDS_ABORT_EN.
// start is taken only while busy is low (no back-pressure, no queuing); valid_flag
// marks plain_data for exactly one cycle and has no ready, the sink must take it.
interface aes_inv_rounds_if;
  import aes_pkg::*;

  logic         start;
  logic [127:0] cipher_text;
  logic [127:0] round_key;
  logic [127:0] plain_data;
  logic [3:0]   round_num;
  logic         valid_flag;
  logic         busy;
  inv_state_e   dbg_state;
`ifdef AES_INV_ROUNDS_ABORT_EN
  logic         abort;
`endif

  modport master (
    output start, cipher_text, round_key,
`ifdef AES_INV_ROUNDS_ABORT_EN
    output abort,
`endif
    input  plain_data, round_num, valid_flag, busy, dbg_state
  );

  modport slave (
    input  start, cipher_text, round_key,
`ifdef AES_INV_ROUNDS_ABORT_EN
    input  abort,
`endif
    output plain_data, round_num, valid_flag, busy, dbg_state
  );

endinterface

// File: rtl/aes_inv_mix_col.sv
// InvMixColumns on one 32-bit column; byte 0 of the column is in bits [31:24].
module aes_inv_mix_col
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o = {
    gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3),
    gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3),
    gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3),
    gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3)
  };

endmodule

// File: rtl/aes_inv_rounds.sv
// Iterative AES decryption, one round per clock, keys fetched by round_num.
// Optional abort input enabled by AES_INV_ROUNDS_ABORT_EN.
module aes_inv_rounds
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  aes_inv_rounds_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_rounds: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] RN_LAST  = 4'(NR);
  localparam logic [3:0] RN_FIRST = 4'(NR - 1);

  inv_state_e   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] pd_q, pd_d;
  logic [3:0]   rn_q, rn_d;
  logic         valid_q, valid_d;

  logic [127:0] isr, isb, ark, imc;
  logic [31:0]  imc_col [4];

  // Row r of the column-major state rotates right by r byte positions.
  always_comb begin : p_inv_shift_rows
    isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127 - 8*(4*c + r) -: 8] = st_q[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
  end

  always_comb begin : p_inv_sub_bytes
    isb = '0;
    for (int i = 0; i < 16; i++) begin
      isb[127 - 8*i -: 8] = inv_sbox(isr[127 - 8*i -: 8]);
    end
  end

  assign ark = isb ^ bus.round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_inv_mix_col u_mix (
      .col_i (ark[127 - 32*c -: 32]),
      .col_o (imc_col[c])
    );
  end

  assign imc = {imc_col[0], imc_col[1], imc_col[2], imc_col[3]};

  always_comb begin : p_next
    state_d = state_q;
    st_d    = st_q;
    rn_d    = rn_q;
    pd_d    = pd_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        rn_d = RN_LAST;
        if (bus.start) begin
          st_d    = bus.cipher_text ^ bus.round_key;
          rn_d    = RN_FIRST;
          state_d = ROUNDS;
        end
      end
      ROUNDS: begin
        st_d = imc;
        rn_d = rn_q - 4'd1;
        if (rn_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        pd_d    = ark;
        valid_d = 1'b1;
        rn_d    = RN_LAST;
        state_d = IDLE;
      end
      default: begin
        rn_d    = RN_LAST;
        state_d = IDLE;
      end
    endcase
`ifdef AES_INV_ROUNDS_ABORT_EN
    // Abort outranks FINAL completion: the block is dropped without a pulse.
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      st_d    = st_q;
      rn_d    = RN_LAST;
      pd_d    = pd_q;
      valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_regs
    if (!reset_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      pd_q    <= '0;
      rn_q    <= RN_LAST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      pd_q    <= pd_d;
      rn_q    <= rn_d;
      valid_q <= valid_d;
    end
  end

  assign bus.plain_data = pd_q;
  assign bus.round_num  = rn_q;
  assign bus.valid_flag = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_aes_inv_rounds.sv
// Directed bench for aes_inv_rounds (NR=10 and NR=14) using FIPS-197 vectors;
// the key schedule and S-box are computed here from GF(2^8) arithmetic.
module tb_aes_inv_rounds;
  import aes_pkg::*;

  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUTs and drive ----------------
  aes_inv_rounds_if bus10 ();
  aes_inv_rounds_if bus14 ();

  aes_inv_rounds #(.NR(10)) u_dut10 (.clk(clk), .reset_n(reset_n), .bus(bus10));
  aes_inv_rounds #(.NR(14)) u_dut14 (.clk(clk), .reset_n(reset_n), .bus(bus14));

  bit           sel14;
  logic         start_drv;
  logic [127:0] ct_drv;
  logic [127:0] rk10 [16];
  logic [127:0] rk14 [16];
  logic [7:0]   sbox_tb [256];

  assign bus10.start       = start_drv & ~sel14;
  assign bus14.start       = start_drv & sel14;
  assign bus10.cipher_text = ct_drv;
  assign bus14.cipher_text = ct_drv;
  assign bus10.round_key   = rk10[bus10.round_num];
  assign bus14.round_key   = rk14[bus14.round_num];
`ifdef AES_INV_ROUNDS_ABORT_EN
  logic abort_drv;
  assign bus10.abort = abort_drv;
  assign bus14.abort = 1'b0;
`endif

  logic [127:0] pd_s;
  logic [3:0]   rn_s;
  logic         valid_s, busy_s;
  assign pd_s    = sel14 ? bus14.plain_data : bus10.plain_data;
  assign rn_s    = sel14 ? bus14.round_num  : bus10.round_num;
  assign valid_s = sel14 ? bus14.valid_flag : bus10.valid_flag;
  assign busy_s  = sel14 ? bus14.busy       : bus10.busy;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr, input bit to14);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (to14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else      rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with the selected DUT idle; returns at a negedge, idle.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input bit chk_rn);
    int nr;
    int early;
    nr = sel14 ? 14 : 10;
    early = 0;
    if (chk_rn) check("rn_idle", 128'(rn_s), 128'(nr));
    start_drv = 1'b1;
    ct_drv = ct;
    exp_q.push_back(pt);
    for (int k = 1; k <= nr; k++) begin
      @(negedge clk);
      start_drv = 1'b0;
      if (valid_s) early++;
      if (k == 1) check("busy_run", 128'(busy_s), 128'd1);
      if (chk_rn) check("rn_seq", 128'(rn_s), 128'(nr - k));
    end
    @(negedge clk);
    check("early_valid", 128'(early), 128'd0);
    check("valid_lat", 128'(valid_s), 128'd1);
    check("busy_done", 128'(busy_s), 128'd0);
    check("plain_data", pd_s, exp_q.pop_front());
    if (chk_rn) check("rn_wrap", 128'(rn_s), 128'(nr));
    @(negedge clk);
    check("valid_pulse", 128'(valid_s), 128'd0);
    check("pd_hold", pd_s, pt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hits;
    reset_n   = 1'b0;
    start_drv = 1'b0;
    ct_drv    = '0;
    sel14     = 1'b0;
`ifdef AES_INV_ROUNDS_ABORT_EN
    abort_drv = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      rk10[i] = '0;
      rk14[i] = '0;
    end
    build_sbox();
    repeat (3) @(negedge clk);

    check("rst_pd", pd_s, 128'd0);
    check("rst_rn10", 128'(rn_s), 128'd10);
    check("rst_valid", 128'(valid_s), 128'd0);
    check("rst_busy", 128'(busy_s), 128'd0);
    check("rst_state10", 128'(bus10.dbg_state), 128'(IDLE));
    check("rst_state14", 128'(bus14.dbg_state), 128'(IDLE));
    check("rst_rn14", 128'(bus14.round_num), 128'd14);
    reset_n = 1'b1;
    @(negedge clk);

    // FIPS-197 App. B
    expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10, 1'b0);
    run_block(B_CT, B_PT, 1'b0);

    // FIPS-197 C.1 with round_num sequence
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, 1'b0);
    run_block(C1_CT, C_PT, 1'b1);

    // FIPS-197 C.3 on the NR=14 instance
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);
    sel14 = 1'b1;
    run_block(C3_CT, C_PT, 1'b0);
    sel14 = 1'b0;

    // Starts while busy are ignored; a start during the valid cycle is taken.
    start_drv = 1'b1;
    ct_drv = C1_CT;
    exp_q.push_back(C_PT);
    hits = 0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      start_drv = (k == 3 || k == 7 || k == 11);
      if (valid_s) hits++;
      if (k == 11 || k == 22) begin
        check("b2b_valid", 128'(valid_s), 128'd1);
        check("b2b_pd", pd_s, exp_q.pop_front());
      end
      if (k == 11) exp_q.push_back(C_PT);
    end
    start_drv = 1'b0;
    check("b2b_pulses", 128'(hits), 128'd2);

    // Asynchronous reset in the middle of a block
    start_drv = 1'b1;
    ct_drv = C1_CT;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_drv = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_pd", pd_s, 128'd0);
    check("mid_rst_rn", 128'(rn_s), 128'd10);
    check("mid_rst_valid", 128'(valid_s), 128'd0);
    check("mid_rst_busy", 128'(busy_s), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hits = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid_s) hits++;
    end
    check("mid_rst_no_valid", 128'(hits), 128'd0);
    run_block(C1_CT, C_PT, 1'b0);

`ifdef AES_INV_ROUNDS_ABORT_EN
    // Abort during rounds: no pulse, plain_data keeps the last result
    start_drv = 1'b1;
    ct_drv = '0;
    hits = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start_drv = 1'b0;
      abort_drv = (k == 6);
      if (k == 7) check("abort_busy", 128'(busy_s), 128'd0);
      if (valid_s) hits++;
    end
    check("abort_no_valid", 128'(hits), 128'd0);
    check("abort_pd_keep", pd_s, C_PT);
    check("abort_rn", 128'(rn_s), 128'd10);

    // Abort in IDLE together with start: start wins
    start_drv = 1'b1;
    abort_drv = 1'b1;
    ct_drv = C1_CT;
    @(negedge clk);
    start_drv = 1'b0;
    abort_drv = 1'b0;
    check("abort_idle_start", 128'(busy_s), 128'd1);
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_s) hits++;
    end
    check("abort_idle_done", 128'(hits), 128'd1);
    check("abort_idle_pd", pd_s, C_PT);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_rounds.md
Name: aes_inv_rounds

Overview:
Iterative AES decryption datapath and FSM. It is the inverse counterpart of the encryption rounds block and processes one round per clock. An external key-schedule block supplies round keys in reverse order, indexed by this block's round_num output. The output plain_data is valid for one cycle, flagged by valid_flag.

Parameters:
- NR, default 10: number of cipher rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Any other value is an elaboration error.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin decryption. Sampled only in IDLE.
- cipher_text, input, 128: ciphertext. Sampled in the cycle start is accepted.
- round_key, input, 128: key for the round index currently on round_num. Must be valid in the same cycle.
- plain_data, output, 128: decrypted block. Registered.
- round_num, output, 4: index of the round key requested this cycle. Registered.
- valid_flag, output, 1: one-cycle pulse; plain_data is valid.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Byte order: bits [127:120] are byte 0. State is column-major: s[r][c] = byte 4c+r.
- Reset values: plain_data=0, round_num=NR, valid_flag=0, busy=0, state=IDLE, internal state register=0.
- FSM states: IDLE, ROUNDS, FINAL.
- IDLE:
  - round_num=NR.
  - If start=1: st <= cipher_text ^ round_key (key NR); round_num <= NR-1; go to ROUNDS.
  - If start=0: stay in IDLE; st holds its value.
- ROUNDS:
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ round_key); round_num <= round_num-1.
  - When round_num==1 this cycle, go to FINAL with round_num=0.
- FINAL:
  - plain_data <= InvSubBytes(InvShiftRows(st)) ^ round_key (key 0); valid_flag <= 1; round_num <= NR; go to IDLE.
- Latency: start accepted at cycle T → valid_flag=1 and plain_data updated at T+NR+1. For NR=10 that is T+11.
- Throughput: one block per NR+1 cycles. valid_flag is high for exactly one cycle.
- plain_data holds its value until the next FINAL or reset.
- start while busy=1 is ignored; no queuing.
- Back-to-back: the block is in IDLE in the same cycle valid_flag is high, so a start in that cycle is accepted.
- InvShiftRows: row r rotates right by r bytes.
- InvSubBytes: FIPS-197 inverse S-box.
- InvMixColumns: per column, multiplies by the matrix {0e 0b 0d 09} (circulant) in GF(2^8), reduction polynomial 0x11B. Multiply is built from xtime chains; integer '*' is not used.
- Reset mid-operation: all outputs and state return to reset values immediately (asynchronous). No valid_flag is produced for the aborted block.
- round_key is not latched; it is combinational into st. The key-schedule block must present the key for the current round_num in the same cycle.

Optional Feature:
- Macro: AES_INV_ROUNDS_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in ROUNDS or FINAL → next state IDLE, round_num=NR, valid_flag stays 0, plain_data is unchanged.
  - abort has priority over FINAL completion.
  - abort in IDLE is ignored, including when start is high in the same cycle: start wins.
- Not defined: no abort port exists. The block always runs to completion once started.

Decomposition:
- Package aes_pkg contains:
  - the FSM state typedef/encoding (IDLE=2'b00, ROUNDS=2'b01, FINAL=2'b11);
  - the inverse S-box as a constant function;
  - gf_xtime, gf_mul09, gf_mul0b, gf_mul0d and gf_mul0e functions;
  - the constant AES_POLY=8'h1B.
- Sub-module aes_inv_mix_col: combinational, 32-bit column in/out. Instantiated four times.
- InvShiftRows and InvSubBytes are inline in the top.

Test Plan:
- FIPS-197 App. B, NR=10: bench key schedule from key 2b7e151628aed2a6abf7158809cf4f3c; ciphertext 3925841d02dc09fbdc118597196a0b32 → plain_data 3243f6a8885a308d313198a2e0370734, with valid_flag at T+11.
- FIPS-197 C.1, NR=10: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plain_data 00112233445566778899aabbccddeeff. Check the round_num sequence 10,9,…,0,10.
- FIPS-197 C.3, NR=14: key 000102…1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 → plain_data 00112233445566778899aabbccddeeff at T+15.
- Start pulsed at T+3 and T+7 during busy → ignored: a single valid_flag at T+11 with the C.1 result. Then a start at T+11 → second result at T+22.
- reset_n low at T+5 → outputs immediately 0/NR/0/0; no valid_flag afterwards; a new start decrypts C.1 correctly.
- AES_INV_ROUNDS_ABORT_EN defined: abort at T+6 → busy=0 at T+7, no valid_flag, plain_data keeps its previous value.
